// File: rtl/lcd_driver.sv
// HD44780-style write-only character LCD driver: captures LCD register writes into a
// small FIFO and replays each entry on the LCD pins with programmable bus timing.
module lcd_driver #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_lcd,
  input  logic        i_lcd_we,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_full,
  output logic        o_ovf
);

  localparam int CW = $clog2(EXEC_LONG_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;

  // Counter is loaded with N-1 on state entry and the state exits when it reaches zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(EXEC_LONG_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [NW-1:0] NUM_ONE  = NW'(1);
  localparam logic [NW-1:0] NUM_ZERO = NW'(0);
  localparam logic [NW-1:0] NUM_FULL = NW'(FIFO_DEPTH);

  // Clear display and return home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    is_long_cmd = !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          on_q, on_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  logic [8:0]    head_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          cnt_done_s;
  logic          pop_s;
  logic          push_s;
  logic          unused_io_s;

  assign unused_io_s = ^{i_io_lcd[30:10], i_io_lcd[8]};

  // FIFO status, pop/push decisions and the timing FSM next state.
  always_comb begin
    head_s       = mem_q[rd_ptr_q];
    fifo_empty_s = (count_q == NUM_ZERO);
    fifo_full_s  = (count_q == NUM_FULL);
    cnt_done_s   = (cnt_q == CNT_ZERO);
    pop_s        = !fifo_empty_s &&
                   ((state_q == ST_IDLE) || ((state_q == ST_EXEC) && cnt_done_s));
    push_s       = i_lcd_we && (!fifo_full_s || pop_s);

    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = head_s[7:0];
          rs_d    = head_s[8];
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_SETUP: begin
        if (cnt_done_s) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_done_s) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_done_s) begin
          state_d = ST_EXEC;
          cnt_d   = is_long_cmd(rs_q, data_q) ? LONG_LD : EXEC_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EXEC: begin
        if (cnt_done_s && pop_s) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = head_s[7:0];
          rs_d    = head_s[8];
        end else if (cnt_done_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FIFO bookkeeping and registered status outputs.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + NUM_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - NUM_ONE;
    end else begin
      count_d = count_q;
    end
    en_d   = (state_d == ST_PULSE);
    on_d   = i_lcd_we ? i_io_lcd[31] : on_q;
    ovf_d  = ovf_q | (i_lcd_we & !push_s);
    busy_d = (count_d != NUM_ZERO) || (state_d != ST_IDLE);
    full_d = (count_d == NUM_FULL);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= NUM_ZERO;
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      data_q   <= 8'd0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      on_q     <= on_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      mem_q[wr_ptr_q] <= {i_io_lcd[9], i_io_lcd[7:0]};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_ovf      = ovf_q;

endmodule
